// File: rtl/transform_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : transform_frame_ctrl                                       |
// | Description : Frame sequencer around a radix-2 DIF transform cascade.    |
// |               Forces exact N-sample input frames (zero-pad short frames, |
// |               drop the tail of long ones), limits frames in flight to    |
// |               MAX_FRAMES and regenerates the output end-of-frame flag.   |
// |               Optional statistics counters are built when the macro      |
// |               TRANSFORM_FRAME_CTRL_STATS_EN is defined.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module transform_frame_ctrl #(
  parameter int WIDTH      = 16,
  parameter int N          = 64,
  parameter int OWIDTH     = 44,
  parameter int MAX_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [2*WIDTH-1:0]   s_data,
  input  logic                 s_last,
  output logic                 f_valid,
  input  logic                 f_ready,
  output logic [2*WIDTH-1:0]   f_data,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [OWIDTH-1:0]    r_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OWIDTH-1:0]    m_data,
  output logic                 m_last,
  output logic                 err_short,
  output logic                 err_long,
  output logic                 busy,
  output logic [15:0]          stat_frames,
  output logic [15:0]          stat_errors
);

  localparam int              CW         = $clog2(N);
  localparam logic [CW-1:0]   LAST_IDX   = CW'(N - 1);
  localparam logic [2:0]      FLIGHT_MAX = 3'(MAX_FRAMES);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] in_count;
  logic [CW-1:0] out_count;
  logic [2:0]    in_flight;
  logic          gate;
  logic          f_xfer;
  logic          m_xfer;
  logic          in_done;
  logic          out_done;

  // A new frame may only start while there is room for another frame in flight
  assign gate     = (in_count == '0) && (in_flight == FLIGHT_MAX);
  assign f_xfer   = f_valid && f_ready;
  assign m_xfer   = m_valid && m_ready;
  assign in_done  = f_xfer && (in_count == LAST_IDX);
  assign out_done = m_xfer && m_last;

  // Output side is a pure pass-through with a regenerated frame marker
  assign m_valid = r_valid;
  assign r_ready = m_ready;
  assign m_data  = r_data;
  assign m_last  = r_valid && (out_count == LAST_IDX);
  assign busy    = (in_count != '0) || (in_flight != '0);

  // Input steering: forward in FILL, inject zeros in PAD, swallow in DROP
  always_comb begin
    f_valid = 1'b0;
    s_ready = 1'b0;
    f_data  = '0;
    case (state)
      FILL: begin
        f_valid = s_valid && !gate;
        s_ready = f_ready && !gate;
        f_data  = s_data;
      end
      PAD: begin
        f_valid = 1'b1;
      end
      DROP: begin
        s_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Framing state machine, input sample index and error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      in_count  <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        FILL: begin
          if (f_xfer) begin
            in_count <= in_count + 1'b1;
            if (s_last && (in_count != LAST_IDX)) begin
              state     <= PAD;
              err_short <= 1'b1;
            end else if (!s_last && (in_count == LAST_IDX)) begin
              state    <= DROP;
              err_long <= 1'b1;
            end
          end
        end
        PAD: begin
          if (f_xfer) begin
            in_count <= in_count + 1'b1;
            if (in_count == LAST_IDX) begin
              state <= FILL;
            end
          end
        end
        DROP: begin
          // in_count sits at zero here: the dropped tail is never forwarded
          if (s_valid && s_last) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Output sample index used to place m_last
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_count <= '0;
    end else if (m_xfer) begin
      out_count <= out_count + 1'b1;
    end
  end

  // Frames accepted but not yet fully emitted; empty-side completions are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      case ({in_done, out_done})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   if (in_flight != '0) in_flight <= in_flight - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef TRANSFORM_FRAME_CTRL_STATS_EN
  // Saturating counters of emitted frames and framing errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_frames <= '0;
      stat_errors <= '0;
    end else begin
      if (out_done && (stat_frames != 16'hFFFF)) begin
        stat_frames <= stat_frames + 1'b1;
      end
      if ((err_short || err_long) && (stat_errors != 16'hFFFF)) begin
        stat_errors <= stat_errors + 1'b1;
      end
    end
  end
`else
  assign stat_frames = '0;
  assign stat_errors = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_transform_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_transform_frame_ctrl                                    |
// | Description : Scoreboard bench for transform_frame_ctrl (N=8,            |
// |               MAX_FRAMES=2) with a delaying cascade model.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_transform_frame_ctrl;

  localparam int WIDTH      = 16;
  localparam int N          = 8;
  localparam int OWIDTH     = 38;
  localparam int MAX_FRAMES = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [2*WIDTH-1:0]  s_data = '0;
  logic                s_last = 1'b0;
  logic                f_valid;
  logic                f_ready = 1'b0;
  logic [2*WIDTH-1:0]  f_data;
  logic                r_valid = 1'b0;
  logic                r_ready;
  logic [OWIDTH-1:0]   r_data = '0;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [OWIDTH-1:0]   m_data;
  logic                m_last;
  logic                err_short;
  logic                err_long;
  logic                busy;
  logic [15:0]         stat_frames;
  logic [15:0]         stat_errors;

  transform_frame_ctrl #(
    .WIDTH(WIDTH), .N(N), .OWIDTH(OWIDTH), .MAX_FRAMES(MAX_FRAMES)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err_short(err_short), .err_long(err_long), .busy(busy),
    .stat_frames(stat_frames), .stat_errors(stat_errors)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {m_last, m_data} expected in order
  logic [OWIDTH:0] exp_q[$];
  logic [31:0]     cur[$];
  int exp_short = 0, exp_long = 0, exp_frames = 0;
  int n_short = 0, n_long = 0;

  // stimulus control of the ready lines
  bit rand_mode = 0;
  bit f_rdy_fixed = 1, m_rdy_fixed = 1;

  // cascade model and high-level occupancy model
  logic [31:0] cq[$];
  int          tq[$];
  int cyc = 0;
  int m_in_cnt = 0, m_out_cnt = 0, m_flight = 0, max_flight = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OWIDTH-1:0] xform(input logic [31:0] d);
    return {6'h2D, d};
  endfunction

  // Build a frame of L samples and push the framed result N samples long
  task automatic prep_frame(input int L, input logic [31:0] base, input bit rnd);
    logic [31:0] d;
    cur.delete();
    for (int i = 0; i < L; i++) begin
      d = rnd ? $urandom : base + 32'(i);
      cur.push_back(d);
    end
    for (int i = 0; i < N; i++) begin
      d = (i < L) ? cur[i] : 32'h0;
      exp_q.push_back({(i == N - 1), xform(d)});
    end
    if (L < N) exp_short++;
    if (L > N) exp_long++;
    exp_frames++;
  endtask

  task automatic send_sample(input logic [31:0] d, input bit l);
    int k;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s_ready && k < 2000);
    if (!s_ready) check("s_handshake_timeout", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_cur(input int start);
    for (int i = start; i < cur.size(); i++) send_sample(cur[i], (i == cur.size() - 1));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Cascade model: fixed 3-cycle latency FIFO; also tracks busy/in-flight
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        cq.delete();
        tq.delete();
        m_in_cnt = 0; m_out_cnt = 0; m_flight = 0;
      end else begin
        check("busy", 64'(busy), 64'((m_in_cnt != 0) || (m_flight != 0)));
        if (f_valid && f_ready) begin
          cq.push_back(f_data);
          tq.push_back(cyc);
          if (m_in_cnt == N - 1) m_flight++;
          m_in_cnt = (m_in_cnt + 1) % N;
        end
        if (r_valid && r_ready) begin
          void'(cq.pop_front());
          void'(tq.pop_front());
          if (m_out_cnt == N - 1 && m_flight > 0) m_flight--;
          m_out_cnt = (m_out_cnt + 1) % N;
        end
        if (m_flight > max_flight) max_flight = m_flight;
      end
      @(posedge clk);
      cyc++;
      #1;
      f_ready = rand_mode ? ($urandom_range(0, 3) != 0) : f_rdy_fixed;
      m_ready = rand_mode ? ($urandom_range(0, 2) != 0) : m_rdy_fixed;
      r_valid = (cq.size() > 0) && (cyc - tq[0] >= 3);
      r_data  = r_valid ? xform(cq[0]) : '0;
    end
  end

  // Monitor: compare every downstream transfer against the scoreboard
  initial begin
    logic [OWIDTH:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (err_short) n_short++;
        if (err_long)  n_long++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {m_last, m_data}, 64'h0);
          end else begin
            e = exp_q.pop_front();
            check("m_sample", 64'({m_last, m_data}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int k, L;

    // reset state
    @(negedge clk);
    check("rst_f_valid", 64'(f_valid), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'({err_short, err_long}), 64'd0);
    check("rst_stats", 64'({stat_frames, stat_errors}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // normal framing, data 1..8
    prep_frame(8, 32'd1, 0);
    send_cur(0);
    drain();

    // short frame: three zero pads with input held off
    prep_frame(5, 32'd10, 0);
    send_cur(0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("pad_s_ready", 64'(s_ready), 64'd0);
      check("pad_f_word", 64'({f_valid, f_data}), {31'd0, 1'b1, 32'd0});
    end
    @(negedge clk);
    check("pad_resume", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    prep_frame(8, 32'd20, 0);
    send_cur(0);

    // long frame then a normal frame
    prep_frame(11, 32'd30, 0);
    send_cur(0);
    prep_frame(8, 32'd40, 0);
    send_cur(0);
    drain();

    // credit limit with the output stalled
    m_rdy_fixed = 1'b0;
    @(posedge clk);
    #1;
    prep_frame(8, 32'd100, 0);
    send_cur(0);
    prep_frame(8, 32'd200, 0);
    send_cur(0);
    prep_frame(8, 32'd300, 0);
    s_valid = 1'b1;
    s_data  = cur[0];
    s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("credit_s_ready", 64'(s_ready), 64'd0);
    check("credit_f_valid", 64'(f_valid), 64'd0);
    check("credit_busy", 64'(busy), 64'd1);
    m_rdy_fixed = 1'b1;
    seen = 0;
    k = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (m_valid && m_ready && m_last) begin
        seen = 1;
        check("credit_hold_at_last", 64'(s_ready), 64'd0);
      end
    end
    check("credit_m_last_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("credit_reopen", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    send_cur(1);
    drain();

    // randomised lengths and backpressure
    rand_mode = 1;
    for (int f = 0; f < 20; f++) begin
      case ($urandom_range(0, 3))
        0, 1:    L = N;
        2:       L = $urandom_range(1, N - 1);
        default: L = $urandom_range(N + 1, N + 5);
      endcase
      prep_frame(L, 32'd0, 1);
      send_cur(0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rand_mode = 0;
    f_rdy_fixed = 1'b1;
    m_rdy_fixed = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    check("max_in_flight_ok", 64'(max_flight <= MAX_FRAMES), 64'd1);
`ifdef TRANSFORM_FRAME_CTRL_STATS_EN
    check("stat_frames", 64'(stat_frames), 64'(exp_frames));
    check("stat_errors", 64'(stat_errors), 64'(exp_short + exp_long));
`else
    check("stat_frames_tied", 64'(stat_frames), 64'd0);
    check("stat_errors_tied", 64'(stat_errors), 64'd0);
`endif

    // reset in the middle of padding
    m_rdy_fixed = 1'b0;
    @(posedge clk);
    #1;
    send_sample(32'hA1, 1'b0);
    send_sample(32'hA2, 1'b0);
    send_sample(32'hA3, 1'b1);
    exp_short++;
    repeat (3) @(posedge clk);
    #1;
    check("pad_before_reset", 64'(f_valid), 64'd1);
    s_data = '0;
    reset = 1'b1;
    #1;
    check("mid_rst_f_valid", 64'(f_valid), 64'd0);
    check("mid_rst_m_last", 64'(m_last), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err", 64'({err_short, err_long}), 64'd0);
    check("mid_rst_stats", 64'({stat_frames, stat_errors}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_rdy_fixed = 1'b1;
    @(posedge clk);
    #1;
    prep_frame(8, 32'd500, 0);
    send_cur(0);
    drain();

    check("err_short_count", 64'(n_short), 64'(exp_short));
    check("err_long_count", 64'(n_long), 64'(exp_long));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/transform_frame_ctrl.md
Name: transform_frame_ctrl

Overview:
- Frame sequencer in front of and behind the transform stage cascade (radix-2 DIF stages chained `N`, `N/2`, … 2).
- Enforces exact `N`-sample framing into the cascade:
  - zero-pads short frames;
  - discards overlong frames.
- Limits the number of frames in flight to `MAX_FRAMES`.
- Regenerates an end-of-frame marker on the cascade output.
- Sits between the sample source (stream with last flag) and the cascade, and between the cascade and the downstream consumer.

Parameters:
- `WIDTH`, 16, I/Q component width of input samples.
- `N`, 64, transform length; power of two, at least 4.
- `OWIDTH`, 44, cascade output sample width (2*WIDTH + 2*log2(N)).
- `MAX_FRAMES`, 2, maximum complete input frames accepted but not yet fully emitted; 1..7.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  upstream ready.
- `s_data`  in  2*WIDTH  upstream sample {Q,I}.
- `s_last`  in  1  upstream end-of-frame flag.
- `f_valid`  out  1  sample valid into cascade.
- `f_ready`  in  1  cascade ready.
- `f_data`  out  2*WIDTH  sample into cascade.
- `r_valid`  in  1  cascade output valid.
- `r_ready`  out  1  cascade output ready.
- `r_data`  in  OWIDTH  cascade output sample.
- `m_valid`  out  1  downstream valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  OWIDTH  downstream sample.
- `m_last`  out  1  downstream end-of-frame.
- `err_short`  out  1  one-cycle pulse: input frame ended early, padding started.
- `err_long`  out  1  one-cycle pulse: `N` samples taken without `s_last`, drop started.
- `busy`  out  1  `in_count != 0` or `in_flight != 0`.
- `stat_frames`  out  16  completed output frames (see Optional Feature).
- `stat_errors`  out  16  `err_short` + `err_long` events (see Optional Feature).

Behaviour:
- **Reset:** asynchronous, active-high. Clears:
  - state to FILL;
  - `in_count`, `out_count` and `in_flight` to 0;
  - `err_short`, `err_long` and both stats to 0.
  - Resulting output values: `f_valid`, `m_valid` and `m_last` are 0; `busy` is 0.
  - Reset mid-frame abandons partial frames; no padding is emitted after release.
- **Handshake:** a transfer occurs when valid && ready. `valid` never depends on `ready`.
- **Input path:** combinational, zero latency.
  - `gate` = (`in_count` == 0 && `in_flight` == `MAX_FRAMES`), evaluated as registered values.
- **FILL state:**
  - `f_valid` = `s_valid` && !`gate`; `s_ready` = `f_ready` && !`gate`; `f_data` = `s_data`.
- **PAD state:**
  - `s_ready` = 0; `f_valid` = 1; `f_data` = 0.
- **DROP state:**
  - `s_ready` = 1; `f_valid` = 0; accepted samples are discarded.
- **`in_count`:** increments on each `f` transfer; wraps from N-1 to 0.
  - A frame completes on an `f` transfer while `in_count` == N-1.
- **Transitions (evaluated on an `f` transfer):**
  - FILL, `s_last`=1, `in_count` < N-1: go to PAD, pulse `err_short`.
  - FILL, `s_last`=0, `in_count` == N-1: go to DROP, pulse `err_long`.
  - FILL, `s_last`=1, `in_count` == N-1: normal frame, stay in FILL.
  - PAD, `in_count` == N-1: go to FILL.
  - DROP: on an accepted sample with `s_last`=1, go to FILL. No `err` pulse in DROP.
- **Output path:** combinational pass-through.
  - `m_valid` = `r_valid`; `r_ready` = `m_ready`; `m_data` = `r_data`.
  - `m_last` = `r_valid` && (`out_count` == N-1).
  - `out_count` increments on each `m` transfer; wraps from N-1 to 0.
- **`in_flight`:**
  - +1 on input frame completion; -1 on an `m` transfer with `m_last`.
  - Both in the same cycle: unchanged.
  - Never exceeds `MAX_FRAMES`, guaranteed by `gate`.
  - An output completion at 0 saturates at 0 (cascade misbehaviour; not counted).
- **Gating:** `gate` holds a new frame start only. A frame already in progress always completes, including PAD.
- **Pulse timing:** `err` pulses are registered and high for exactly the cycle after the triggering transfer.

Optional Feature:
- Macro `TRANSFORM_FRAME_CTRL_STATS_EN`.
- Defined:
  - `stat_frames` increments on each `m_last` transfer.
  - `stat_errors` increments on each `err_short` or `err_long` pulse.
  - Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic is synthesised.

Test Plan:
- **Normal framing:** `N`=8, `MAX_FRAMES`=2; 8 samples 1..8 with `s_last` on the 8th; cascade model delays 3 cycles → `f_data` 1..8 passed through, no `err` pulses; downstream `m_last` on the 8th output; `in_flight` 0→1→0.
- **Short frame:** `N`=8; 5 samples with `s_last` on the 5th → `err_short` pulse; `s_ready`=0 for 3 cycles while `f_data`=0 is transferred 3 times; FILL resumes and the next frame is accepted at `in_count` 0.
- **Long frame:** `N`=8; 11 samples with `s_last` on the 11th → 8 forwarded; `err_long` pulse; samples 9–11 consumed with `f_valid`=0; the 12th sample starts a new frame.
- **Credit limit:** `MAX_FRAMES`=2, `m_ready`=0; send 3 frames → 2 accepted; `s_ready`=0 at the 3rd frame start; `busy`=1; raise `m_ready` → the first `m_last` transfer reopens the input the next cycle.
- **Backpressure and simultaneity:** randomised `f_ready`/`m_ready` with an input completion and an `m_last` transfer in the same cycle → `in_flight` unchanged; no sample loss or duplication versus the reference model over 20 frames.
- **Reset mid-frame:** assert `reset` after 3 samples of PAD → all outputs 0 immediately; after release, FILL with `in_count`=0; with the macro defined, stats read 0.
